// File: rtl/pwm_multi.sv
// Multi-channel Avalon-MM PWM: one shared prescaler and period counter, per-channel
// double-buffered duty with polarity, edge or center alignment, boundary event/irq.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PERIOD   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(3);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic              en, center, irq_en, evt;
  logic [NUM_CH-1:0] pol, raw;
  logic [CNT_W-1:0]  period_sh, period_sh_nxt, period_act, prescale;
  logic [CNT_W-1:0]  pre_cnt, cnt, cnt_nxt;
  logic [CNT_W-1:0]  duty_sh     [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_nxt [NUM_CH];
  logic [CNT_W-1:0]  duty_act    [NUM_CH];
  logic              wr_en, tick, boundary;
  dir_t              dir, dir_nxt;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign wr_en        = chipselect & write;
  assign irq          = evt & irq_en;
  assign unused_wdata = ^writedata;

  // Shadow values as they will be after this edge, so a boundary load sees a same-edge write.
  always_comb begin
    period_sh_nxt = period_sh;
    if (wr_en && address == A_PERIOD) period_sh_nxt = writedata[CNT_W-1:0];
    for (int n = 0; n < NUM_CH; n++) begin
      duty_sh_nxt[n] = duty_sh[n];
      if (wr_en && address == ADDR_W'(4 + n)) duty_sh_nxt[n] = writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    tick     = en && (pre_cnt >= prescale);
    boundary = 1'b0;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    if (tick) begin
      if (!center) begin
        if (cnt >= period_act) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end else if (period_act == '0) begin
        cnt_nxt  = '0;
        dir_nxt  = DIR_UP;
        boundary = 1'b1;
      end else if (dir == DIR_DOWN || cnt >= period_act) begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt  = '0;
          dir_nxt  = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          dir_nxt = DIR_DOWN;
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) raw[n] = (cnt < duty_act[n]);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL: begin
        rd_mux[0]           = en;
        rd_mux[1]           = center;
        rd_mux[2]           = irq_en;
        rd_mux[8 +: NUM_CH] = pol;
      end
      A_PERIOD:   rd_mux[CNT_W-1:0] = period_sh;
      A_PRESCALE: rd_mux[CNT_W-1:0] = prescale;
      A_STATUS:   rd_mux[0]         = evt;
      default:    ;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (address == ADDR_W'(4 + n)) rd_mux[CNT_W-1:0] = duty_sh[n];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en         <= 1'b0;
      center     <= 1'b0;
      irq_en     <= 1'b0;
      pol        <= '0;
      evt        <= 1'b0;
      period_sh  <= '0;
      period_act <= '0;
      prescale   <= '0;
      pre_cnt    <= '0;
      cnt        <= '0;
      dir        <= DIR_UP;
      pwm_out    <= '0;
      readdata   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh[n]  <= '0;
        duty_act[n] <= '0;
      end
    end else begin
      if (wr_en && address == A_CTRL) begin
        en     <= writedata[0];
        center <= writedata[1];
        irq_en <= writedata[2];
        pol    <= writedata[8 +: NUM_CH];
      end
      if (wr_en && address == A_PRESCALE) prescale <= writedata[CNT_W-1:0];

      period_sh <= period_sh_nxt;
      for (int n = 0; n < NUM_CH; n++) duty_sh[n] <= duty_sh_nxt[n];

      // While disabled the active copies follow the shadows so enabling starts clean.
      if (!en || boundary) begin
        period_act <= period_sh_nxt;
        for (int n = 0; n < NUM_CH; n++) duty_act[n] <= duty_sh_nxt[n];
      end

      if (boundary) evt <= 1'b1;
      else if (wr_en && address == A_STATUS && writedata[0]) evt <= 1'b0;

      if (!en) begin
        pre_cnt <= '0;
        cnt     <= '0;
        dir     <= DIR_UP;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
        cnt     <= cnt_nxt;
        dir     <= dir_nxt;
      end
      if (wr_en && address == A_CTRL && writedata[1] != center) dir <= DIR_UP;

      pwm_out <= en ? (raw ^ pol) : pol;

      if (chipselect && read) readdata <= rd_mux;
    end
  end

endmodule
